// File: rtl/dmem_byte_responder.sv
// dmem_byte_responder
// Responder side of the core's load/store data-memory interface. One request
// is accepted at a time and serialised onto a byte-wide RAM, one byte per
// clock, little-endian. Loads return a sign/zero-extended 64-bit value; stores
// return a completion. Either way the response is a single-cycle pulse.
//
// Parameters:
//   DEPTH      bytes in the RAM, indices 0..DEPTH-1
//   INIT_FILE  initial image name (no file is read by this model)
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_funct3           [1:0] size code (1/2/4/8 bytes), [2] unsigned-load flag
//   req_addr             64-bit byte address, may be misaligned
//   req_wdata            store data, low 8*size bits used
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            extended load value; 0 for stores, errors and idle
//   rsp_err              qualifies rsp_valid: request rejected, no RAM access
//   busy                 FSM not idle
//
// Optional feature: define DMEM_BOUNDS_CHECK_EN to reject accesses with
// req_addr+size > DEPTH instead of wrapping the byte index modulo DEPTH.
//
// Handshake: a request is taken on any rising edge where req_ready (FSM idle)
// and req_valid are both high; all req_* fields are captured on that edge.
// req_valid while busy is ignored, so the initiator must hold the request
// until req_ready is high. rsp_valid needs no acknowledge.
module dmem_byte_responder #(
  parameter int    DEPTH     = 129,
  parameter string INIT_FILE = "data.mem"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] result_q, result_d;

  logic [7:0]       mem [DEPTH];
  logic [63:0]      byte_addr;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cap_size;
  logic             last_byte;
  logic             mem_we;
  logic [7:0]       wr_byte;
  logic             illegal_req;
  logic             out_of_range;
  logic             sx;
  logic [63:0]      ext_result;

  // Full 64-bit sum first, then the modulo, so an address near 2^64 wraps
  // through zero before being folded onto the RAM.
  assign byte_addr = addr_q + 64'(cnt_q);
  assign idx       = IDX_W'(byte_addr % 64'(DEPTH));
  assign cap_size  = 4'd1 << funct3_q[1:0];
  assign last_byte = (4'(cnt_q) == (cap_size - 4'd1));
  assign wr_byte   = wdata_q[{cnt_q, 3'b000} +: 8];
  assign mem_we    = (state_q == XFER) && we_q && !err_q;

  assign illegal_req = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef DMEM_BOUNDS_CHECK_EN
  logic [3:0] req_size;
  assign req_size     = 4'd1 << req_funct3[1:0];
  // 65-bit compare so an address near 2^64 cannot wrap back into range.
  assign out_of_range = ({1'b0, req_addr} + 65'(req_size)) > 65'(DEPTH);
`else
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    err_d    = err_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = illegal_req || out_of_range;
          cnt_d    = 3'd0;
          result_d = 64'd0;
          // A rejected request still spends one XFER cycle (with the RAM
          // untouched) so that its response lands after E1 like a byte access.
          state_d  = XFER;
        end
      end
      XFER: begin
        if (!err_q && !we_q) begin
          result_d[{cnt_q, 3'b000} +: 8] = mem[idx];
        end
        if (err_q || last_byte) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'd0;
      cnt_q    <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      err_q    <= err_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
    end
  end

  // RAM is never cleared; a reset edge only blocks the write on that edge.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[idx] <= wr_byte;
    end
  end

  // funct3[2]=0 sign-extends; an 8-byte access has nothing to extend.
  always_comb begin
    sx = ~funct3_q[2];
    case (funct3_q[1:0])
      2'd0:    ext_result = {{56{sx & result_q[7]}},  result_q[7:0]};
      2'd1:    ext_result = {{48{sx & result_q[15]}}, result_q[15:0]};
      2'd2:    ext_result = {{32{sx & result_q[31]}}, result_q[31:0]};
      default: ext_result = result_q;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ext_result : 64'd0;

endmodule

// File: tb/tb_dmem_byte_responder.sv
module tb_dmem_byte_responder;

  localparam int DEPTH = 129;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_byte_responder #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]  model_mem [DEPTH];
  // {due cycle[31:0], err, rdata[63:0]}
  logic [96:0] exp_q[$];

  function automatic int idx_of(input logic [63:0] a, input int k);
    logic [63:0] s;
    s = a + 64'(k);
    return int'(s % 64'(DEPTH));
  endfunction

  // Applies a request to the model RAM and yields the expected response.
  // max_bytes limits how many bytes take effect (for an aborted access).
  task automatic model_apply(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input int max_bytes,
                             output bit err, output logic [63:0] rd, output int lat);
    int n;
    n   = 1 << f3[1:0];
    err = (f3 == 3'b111) || (we && f3[2]);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (!err && (({1'b0, addr} + 65'(n)) > 65'(DEPTH))) err = 1'b1;
`endif
    rd  = 64'd0;
    lat = err ? 1 : n;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (k < max_bytes) begin
          if (we) model_mem[idx_of(addr, k)] = wd[8*k +: 8];
          else    rd[8*k +: 8] = model_mem[idx_of(addr, k)];
        end
      end
      if (!we && !f3[2] && n < 8 && rd[8*n-1]) rd = rd | ~((64'd1 << (8*n)) - 64'd1);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input bit track);
    int waited;
    bit ok;
    bit rdy;
    bit err;
    logic [63:0] rd;
    int lat;
    waited = 0;
    ok     = 1'b0;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    // Held while busy; taken on the first edge that sees req_ready high.
    while (!ok && waited < 100) begin
      rdy = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) ok = 1'b1;
      else     waited++;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
    end else if (track) begin
      model_apply(we, f3, addr, wd, 8, err, rd, lat);
      exp_q.push_back({32'(cyc + lat), err, rd});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata,      64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [96:0] e;
    if (reset) begin
      check("busy_vs_ready", 64'(busy), 64'(!req_ready));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h err=%b, required no response",
                   rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(e[96:65]));
          check("rsp_err",   64'(rsp_err), 64'(e[64]));
          check("rsp_rdata", rsp_rdata, e[63:0]);
        end
      end else if (req_ready) begin
        check("idle_rdata", rsp_rdata, 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          d_err;
    logic [63:0] d_rd;
    int          d_lat;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;

    // Give every RAM byte a known value.
    for (int i = 0; i < 16; i++) issue(1'b1, 3'b011, 64'(8*i), {$urandom, $urandom}, 1'b1);
    issue(1'b1, 3'b000, 64'd128, {$urandom, $urandom}, 1'b1);

    // T1
    issue(1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 1'b1);
    issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'h10, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'h17, 64'd0, 1'b1);
    // T2
    issue(1'b1, 3'b000, 64'h20, 64'h80, 1'b1);
    issue(1'b0, 3'b000, 64'h20, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'h20, 64'd0, 1'b1);
    // T3
    issue(1'b1, 3'b010, 64'h31, 64'hDEADBEEF, 1'b1);
    issue(1'b0, 3'b001, 64'h33, 64'd0, 1'b1);
    issue(1'b0, 3'b110, 64'h31, 64'd0, 1'b1);
    issue(1'b0, 3'b010, 64'h31, 64'd0, 1'b1);
    issue(1'b0, 3'b101, 64'h33, 64'd0, 1'b1);
    // T4
    issue(1'b0, 3'b111, 64'h20, 64'd0, 1'b1);
    issue(1'b1, 3'b100, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(1'b1, 3'b111, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(1'b0, 3'b011, 64'h20, 64'd0, 1'b1);

    // T5: abort an SD with reset after three bytes have been written.
    issue(1'b1, 3'b011, 64'h40, 64'd0, 1'b1);
    drain();
    issue(1'b1, 3'b011, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    model_apply(1'b1, 3'b011, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 3, d_err, d_rd, d_lat);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b1;
    issue(1'b0, 3'b011, 64'h40, 64'd0, 1'b1);

    // T6: wrap (or reject) at the top of the RAM.
    issue(1'b1, 3'b010, 64'd126, 64'h44332211, 1'b1);
    issue(1'b0, 3'b100, 64'd126, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'd127, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'd128, 64'd0, 1'b1);
    issue(1'b0, 3'b100, 64'd0,   64'd0, 1'b1);
    issue(1'b0, 3'b010, 64'd126, 64'd0, 1'b1);
    // 64-bit address wrap through zero.
    issue(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1);
    issue(1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA55A, 1'b1);
    issue(1'b0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      logic [63:0] a;
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      else                           a = 64'($urandom_range(0, 140));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, 1'b1);
    end

    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
